// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_t;

   // Word-index width for a given depth; a single-word store still needs one bit.
   function automatic int idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / response bus between the program-counter side and the responder.
interface imem_responder_if;
   import imem_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [ADDR_W-1:0]  req_addr;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [INSTR_W-1:0] rsp_instr;
   logic               rsp_fault;
   logic [ADDR_W-1:0]  rsp_addr;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_addr
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_addr
   );

endinterface

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
module imem_array
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic [idx_w(DEPTH_WORDS)-1:0]   widx,
   input  logic [INSTR_W-1:0]              wdata,
   input  logic [idx_w(DEPTH_WORDS)-1:0]   ridx,
   output logic [INSTR_W-1:0]              rdata
);

   logic [INSTR_W-1:0] mem [DEPTH_WORDS];

   // NOTE: storage has no reset so it maps onto RAM; contents are undefined until loaded.
   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   // A same-edge write lands after this read is sampled, giving read-before-write.
   assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one PC fetch, waits WAIT_CYCLES, returns the word or a fault.
module imem_responder
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic                          clk,
   input  logic                          reset,
   imem_responder_if.slave               bus,
   input  logic                          load_en,
   input  logic [idx_w(DEPTH_WORDS)-1:0] load_idx,
   input  logic [INSTR_W-1:0]            load_data
);

   localparam int          IDX_W     = idx_w(DEPTH_WORDS);
   localparam logic [63:0] SPAN      = 64'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   imem_state_t        state, state_nxt;
   logic [3:0]         cnt;
   logic [ADDR_W-1:0]  pend_addr;
   logic [ADDR_W-1:0]  cap_addr;
   logic [ADDR_W-1:0]  cap_off;
   logic               cap_fault;
   logic [IDX_W-1:0]   cap_idx;
   logic [INSTR_W-1:0] rd_data;
   logic               accept;
   logic               capture;
   logic               rsp_hs;
   logic [INSTR_W-1:0] rsp_instr_q;
   logic               rsp_fault_q;
   logic [ADDR_W-1:0]  rsp_addr_q;

   assign accept  = bus.req_valid && (state == IDLE) && !reset;
   assign rsp_hs  = (state == RESP) && bus.rsp_ready;
   assign capture = (state_nxt == RESP) && (state != RESP);

   // With zero wait states the capture edge is the accept edge, so read the live request.
   assign cap_addr  = (state == IDLE) ? bus.req_addr : pend_addr;
   assign cap_off   = cap_addr - BASE_ADDR;
   assign cap_fault = (cap_addr[1:0] != 2'b00) || (cap_off >= SPAN);
   assign cap_idx   = cap_off[2 +: IDX_W];

   imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .we    (load_en),
      .widx  (load_idx),
      .wdata (load_data),
      .ridx  (cap_idx),
      .rdata (rd_data)
   );

   // NOTE: every register here uses non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT: if (cnt == 4'd0) state_nxt = RESP;
         RESP: if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == IDLE) && !reset;
      bus.rsp_valid = (state == RESP);
      bus.rsp_instr = rsp_instr_q;
      bus.rsp_fault = rsp_fault_q;
      bus.rsp_addr  = rsp_addr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 4'd0;
         pend_addr <= '0;
      end else if (accept) begin
         cnt       <= WAIT_INIT;
         pend_addr <= bus.req_addr;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Response fields only change on the edge entering RESP, so they hold through a stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_instr_q <= '0;
         rsp_fault_q <= 1'b0;
         rsp_addr_q  <= '0;
      end else if (capture) begin
         rsp_instr_q <= cap_fault ? '0 : rd_data;
         rsp_fault_q <= cap_fault;
         rsp_addr_q  <= cap_addr;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: three responders (WAIT 1 / base 0, WAIT 0 / base 0x8000_0000, WAIT 3 / base 0).
module tb_imem_responder;
   import imem_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
      logic [63:0] addr;
      int          acc_cyc;
      int          lat;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        rv       [3];
   logic [63:0] ra       [3];
   logic        rr       [3];
   logic        le       [3];
   logic [9:0]  li;
   logic [31:0] ld;
   logic        rq_ready [3];
   logic        rs_valid [3];
   logic [31:0] rs_instr [3];
   logic        rs_fault [3];
   logic [63:0] rs_addr  [3];

   exp_t        exp_q [3][$];
   logic        pv     [3];
   logic [31:0] h_instr [3];
   logic        h_fault [3];
   logic [63:0] h_addr  [3];
   int          cyc;
   int          n_tests;
   int          n_fail;

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int unsigned WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      localparam logic [63:0] BA = (g == 1) ? 64'h8000_0000 : 64'h0;
      imem_responder_if bus ();
      assign bus.req_valid = rv[g];
      assign bus.req_addr  = ra[g];
      assign bus.rsp_ready = rr[g];
      assign rq_ready[g]   = bus.req_ready;
      assign rs_valid[g]   = bus.rsp_valid;
      assign rs_instr[g]   = bus.rsp_instr;
      assign rs_fault[g]   = bus.rsp_fault;
      assign rs_addr[g]    = bus.rsp_addr;
      imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC), .BASE_ADDR(BA)) dut (
         .clk       (clk),
         .reset     (reset),
         .bus       (bus),
         .load_en   (le[g]),
         .load_idx  (li),
         .load_data (ld)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compare on each rising rsp_valid, then check the held fields stay put.
   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < 3; g++) begin
         if (reset) begin
            pv[g] = 1'b0;
         end else begin
            if (rs_valid[g] && !pv[g]) begin
               check($sformatf("sb_pending[%0d]", g), 64'(exp_q[g].size() != 0), 64'd1);
               if (exp_q[g].size() != 0) begin
                  e = exp_q[g].pop_front();
                  check($sformatf("rsp_instr[%0d]", g), 64'(rs_instr[g]), 64'(e.instr));
                  check($sformatf("rsp_fault[%0d]", g), 64'(rs_fault[g]), 64'(e.fault));
                  check($sformatf("rsp_addr[%0d]", g), rs_addr[g], e.addr);
                  check($sformatf("latency[%0d]", g), 64'(cyc - e.acc_cyc), 64'(e.lat));
               end
               h_instr[g] = rs_instr[g];
               h_fault[g] = rs_fault[g];
               h_addr[g]  = rs_addr[g];
            end else if (rs_valid[g]) begin
               check($sformatf("hold_instr[%0d]", g), 64'(rs_instr[g]), 64'(h_instr[g]));
               check($sformatf("hold_fault[%0d]", g), 64'(rs_fault[g]), 64'(h_fault[g]));
               check($sformatf("hold_addr[%0d]", g), rs_addr[g], h_addr[g]);
            end
            if (rs_valid[g]) check($sformatf("req_ready_in_resp[%0d]", g), 64'(rq_ready[g]), 64'd0);
            pv[g] = rs_valid[g];
         end
      end
   end

   task automatic wait_ready(input int g);
      int n = 0;
      while (!rq_ready[g] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("ready_timeout[%0d]", g), 64'(rq_ready[g]), 64'd1);
   endtask

   task automatic wait_valid(input int g);
      int n = 0;
      while (!rs_valid[g] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("valid_timeout[%0d]", g), 64'(rs_valid[g]), 64'd1);
   endtask

   // Presents one request at a negedge; returns at the negedge after the accept edge.
   task automatic fetch(input int g, input logic [63:0] addr, input logic [31:0] instr,
                        input logic fault, input int lat);
      exp_t e;
      wait_ready(g);
      rv[g] = 1'b1;
      ra[g] = addr;
      e.instr = instr; e.fault = fault; e.addr = addr; e.acc_cyc = cyc; e.lat = lat;
      exp_q[g].push_back(e);
      @(negedge clk);
      rv[g] = 1'b0;
   endtask

   task automatic load(input int g, input logic [9:0] idx, input logic [31:0] data);
      le[g] = 1'b1; li = idx; ld = data;
      @(negedge clk);
      le[g] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   localparam logic [31:0] W0 = 32'h0000_0013;
   localparam logic [31:0] W1 = 32'h0010_0093;
   localparam logic [31:0] W2 = 32'h0020_8113;
   localparam logic [31:0] W3 = 32'h0000_006F;
   localparam logic [31:0] WL = 32'h0000_0073;

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b1;
      li = '0; ld = '0;
      for (int g = 0; g < 3; g++) begin
         rv[g] = 1'b0; ra[g] = '0; rr[g] = 1'b1; le[g] = 1'b0; pv[g] = 1'b0;
      end
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rst_valid[%0d]", g), 64'(rs_valid[g]), 64'd0);
         check($sformatf("rst_instr[%0d]", g), 64'(rs_instr[g]), 64'd0);
         check($sformatf("rst_fault[%0d]", g), 64'(rs_fault[g]), 64'd0);
         check($sformatf("rst_addr[%0d]", g), rs_addr[g], 64'd0);
         check($sformatf("rst_ready[%0d]", g), 64'(rq_ready[g]), 64'd1);
      end

      // Preload the same program into every responder.
      for (int g = 0; g < 3; g++) le[g] = 1'b1;
      li = 10'd0;    ld = W0; @(negedge clk);
      li = 10'd1;    ld = W1; @(negedge clk);
      li = 10'd2;    ld = W2; @(negedge clk);
      li = 10'd3;    ld = W3; @(negedge clk);
      li = 10'd1023; ld = WL; @(negedge clk);
      for (int g = 0; g < 3; g++) le[g] = 1'b0;

      // Responder 0: one wait state, base 0.
      fetch(0, 64'h4,    W1,    1'b0, 2);
      fetch(0, 64'h6,    32'h0, 1'b1, 2);
      fetch(0, 64'h1000, 32'h0, 1'b1, 2);
      fetch(0, 64'hFFC,  WL,    1'b0, 2);
      drain();

      // Stall in RESP; a competing request must be ignored.
      wait_ready(0);
      rr[0] = 1'b0;
      fetch(0, 64'hC, W3, 1'b0, 2);
      wait_valid(0);
      rv[0] = 1'b1; ra[0] = 64'h10;
      repeat (5) @(negedge clk);
      rv[0] = 1'b0; rr[0] = 1'b1;
      @(negedge clk);
      check("release_ready", 64'(rq_ready[0]), 64'd1);
      check("release_valid", 64'(rs_valid[0]), 64'd0);
      drain();

      // Responder 1: zero wait states, base 0x8000_0000.
      fetch(1, 64'h8000_0008, W2,    1'b0, 1);
      fetch(1, 64'h7FFF_FFFC, 32'h0, 1'b1, 1);
      fetch(1, 64'h8000_0FFC, WL,    1'b0, 1);
      fetch(1, 64'h8000_1000, 32'h0, 1'b1, 1);
      drain();
      // Load on the accept/capture edge returns the old word; the next fetch sees the new one.
      wait_ready(1);
      le[1] = 1'b1; li = 10'd3; ld = 32'h1234_5678;
      fetch(1, 64'h8000_000C, W3, 1'b0, 1);
      le[1] = 1'b0;
      fetch(1, 64'h8000_000C, 32'h1234_5678, 1'b0, 1);
      drain();

      // Responder 2: three wait states for load-ordering cases.
      fetch(2, 64'h8, 32'hDEAD_BEEF, 1'b0, 4);
      load(2, 10'd2, 32'hDEAD_BEEF);
      fetch(2, 64'h8, 32'hDEAD_BEEF, 1'b0, 4);
      repeat (2) @(negedge clk);
      load(2, 10'd2, 32'h1111_1111);
      drain();
      wait_ready(2);
      rr[2] = 1'b0;
      fetch(2, 64'h8, 32'h1111_1111, 1'b0, 4);
      wait_valid(2);
      load(2, 10'd2, 32'h2222_2222);
      repeat (3) @(negedge clk);
      rr[2] = 1'b1;
      fetch(2, 64'h8, 32'h2222_2222, 1'b0, 4);
      drain();

      // Reset in WAIT drops the fetch and clears outputs immediately.
      fetch(0, 64'h0, W0, 1'b0, 2);
      #2 reset = 1'b1;
      #1;
      check("async_valid", 64'(rs_valid[0]), 64'd0);
      check("async_instr", 64'(rs_instr[0]), 64'd0);
      check("async_fault", 64'(rs_fault[0]), 64'd0);
      check("async_addr",  rs_addr[0], 64'd0);
      void'(exp_q[0].pop_back());
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_valid", 64'(rs_valid[0]), 64'd0);
         check("post_rst_ready", 64'(rq_ready[0]), 64'd1);
      end
      fetch(0, 64'h4, W1, 1'b0, 2);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch address produced by the program counter register.
- Accepts one fetch request carrying a 64-bit PC and returns the 32-bit instruction word at that address after a configurable number of wait states.
- Flags misaligned and out-of-range fetches.
- Provides a side load port used by the bench/boot path to preload program words.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words stored (power of two).
- WAIT_CYCLES, 1, extra cycles between request accept and response (0..15).
- BASE_ADDR, 64'h0, byte address of word 0.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  one clock; reset is asynchronous and active-high.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  64  fetch byte address (PC).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_instr  output  32  instruction word; 0 on fault.
- rsp_fault  output  1  misaligned or out-of-range fetch.
- rsp_addr  output  64  echo of accepted req_addr.
- load_en  input  1  write one program word this cycle.
- load_idx  input  $clog2(DEPTH_WORDS)  word index to write.
- load_data  input  32  word to write.

Behaviour:
- States: IDLE, WAIT, RESP (enum in package).
- Reset (async assert, sync release):
  - state=IDLE, counter=0.
  - rsp_valid=0, rsp_instr=0, rsp_fault=0, rsp_addr=0.
  - req_ready=1 after reset releases.
  - Array contents are not reset.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch req_addr and compute fault.
  - Next state is WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else RESP.
- Fault rule:
  - Fault if req_addr[1:0]!=0, or if off = req_addr-BASE_ADDR (64-bit unsigned, wrap allowed) satisfies off >= DEPTH_WORDS*4.
  - Addresses below BASE_ADDR wrap to a huge offset and therefore fault.
  - Word index = off[2+:$clog2(DEPTH_WORDS)].
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 0, next state is RESP.
- Transition into RESP:
  - Capture rsp_instr = fault ? 0 : array[index], plus rsp_fault and rsp_addr.
  - Capture happens on the edge entering RESP.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_instr, rsp_fault and rsp_addr are held stable until rsp_valid && rsp_ready.
  - Handshake returns to IDLE with rsp_valid=0 the next cycle.
  - No request is accepted in the handshake cycle.
- Latency: rsp_valid asserts exactly WAIT_CYCLES+1 cycles after the accept edge. Throughput is at most one fetch per WAIT_CYCLES+2 cycles.
- Load port:
  - Write-only, accepted in any state, independent of the handshake.
  - A load to the pending index before the RESP capture edge is visible in the response.
  - A load on the capture edge itself returns the old word (read-before-write).
  - A load after capture does not alter the held response.
- req_addr and req_valid are ignored outside IDLE.
- Reset mid-transaction (WAIT or RESP) drops the pending fetch; no response is issued.

Decomposition:
- imem_pkg:
  - state enum imem_state_t {IDLE, WAIT, RESP}.
  - INSTR_W=32.
  - Localparam helper for index width.
- Sub-module imem_array:
  - DEPTH_WORDS x 32 storage.
  - One synchronous write port (load_*).
  - One combinational read port.
  - Read-before-write on a same-edge collision.
- imem_responder holds the FSM, counter, fault logic and response registers.

Test Plan:
- Preload idx 0..3 = 32'h00000013, 32'h00100093, 32'h00208113, 32'h0000006F; WAIT_CYCLES=1; fetch 64'h4 -> rsp_valid rises 2 cycles after accept, rsp_instr=32'h00100093, rsp_fault=0, rsp_addr=64'h4.
- Fetch 64'h6 -> rsp_fault=1, rsp_instr=0, rsp_addr=64'h6; fetch 64'h1000 with DEPTH_WORDS=1024 -> rsp_fault=1; fetch 64'hFFC -> valid word 1023, no fault.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and all rsp_* stable; req_ready=0 throughout; a second req_valid is ignored; release rsp_ready -> IDLE, req_ready=1 the next cycle.
- WAIT_CYCLES=0 -> response one cycle after accept. Load idx 2 = 32'hDEADBEEF while fetch 64'h8 is in WAIT -> rsp_instr=32'hDEADBEEF. A load on the capture edge -> old value returned.
- Assert reset during WAIT -> rsp_valid stays 0 and all outputs read 0 immediately (asynchronous). After release, req_ready=1 and a new fetch completes normally.
- BASE_ADDR=64'h8000_0000: fetch 64'h8000_0008 -> idx 2 returned; fetch 64'h7FFF_FFFC -> rsp_fault=1 (wrapped offset).
